// File: rtl/haze_pkg.sv
// haze_pkg: shared widths, defaults, pixel type and the reference divide
// for the haze synthesizer.
//   PIX_W / SUM_W / LAT : channel width, product-sum width, pipeline depth
//   T_MIN_DEF           : default lower clamp on transmittance
//   A_RESET_DEF         : atmospheric-light shadow value after reset
//   VSYNC_POL_DEF       : default active level of vsync
//   rgb_t               : packed {R, G, B} pixel
//   div255_floor        : exact floor(s/255), the golden reference
package haze_pkg;

  localparam int PIX_W = 8;
  localparam int SUM_W = 16;
  localparam int LAT   = 3;

  localparam logic [PIX_W-1:0] T_MIN_DEF     = 8'd26;
  localparam logic [PIX_W-1:0] A_RESET_DEF   = 8'd255;
  localparam logic             VSYNC_POL_DEF = 1'b1;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  function automatic logic [PIX_W-1:0] div255_floor(input logic [SUM_W-1:0] s);
    logic [SUM_W-1:0] q;
    q = s / 16'd255;
    return q[PIX_W-1:0];
  endfunction

endpackage

// File: rtl/haze_channel.sv
// haze_channel: per-channel haze math, 2-cycle latency.
//   pixelclk, reset : clock and synchronous active-high reset
//   i_j             : clear channel value J
//   i_tc            : clamped transmittance
//   i_a             : atmospheric light A
//   i_bypass        : pass J through instead of the hazy value
//   o_i             : hazy channel value I (registered)
module haze_channel
  import haze_pkg::*;
(
  input  logic             pixelclk,
  input  logic             reset,
  input  logic [PIX_W-1:0] i_j,
  input  logic [PIX_W-1:0] i_tc,
  input  logic [PIX_W-1:0] i_a,
  input  logic             i_bypass,
  output logic [PIX_W-1:0] o_i
);

  logic [SUM_W-1:0] w_prod_j;
  logic [SUM_W-1:0] w_prod_a;
  logic [PIX_W-1:0] w_inv_tc;
  logic [SUM_W-1:0] w_adj;
  logic [PIX_W-1:0] w_quot;

  logic [SUM_W-1:0] r_sum;
  logic [PIX_W-1:0] r_j_s2;
  logic             r_byp_s2;
  logic [PIX_W-1:0] r_out;

  assign w_inv_tc = 8'd255 - i_tc;
  assign w_prod_j = SUM_W'(i_j) * SUM_W'(i_tc);
  assign w_prod_a = SUM_W'(i_a) * SUM_W'(w_inv_tc);

  // floor(S/255) as (S + (S>>8) + 1) >> 8. Write S = 255q + r, 0<=r<=254.
  // If r >= q then S>>8 = q and the sum is 256q + r + 1 (r+1 <= 255).
  // If r <  q then S>>8 = q-1 and the sum is 256q + r.
  // Both give q for q <= 255, i.e. every S up to 65279 >= 65025.
  // The sum peaks at 65025 + 254 + 1 = 65280, so 16 bits cannot wrap.
  assign w_adj  = r_sum + {8'd0, r_sum[SUM_W-1:PIX_W]} + 16'd1;
  assign w_quot = PIX_W'(w_adj >> PIX_W);

  always_ff @(posedge pixelclk) begin
    if (reset) begin
      r_sum    <= '0;
      r_j_s2   <= '0;
      r_byp_s2 <= 1'b0;
      r_out    <= '0;
    end else begin
      // S2: weighted sum, max 255*255 = 65025
      r_sum    <= w_prod_j + w_prod_a;
      r_j_s2   <= i_j;
      r_byp_s2 <= i_bypass;
      // S3: divide or bypass
      r_out    <= r_byp_s2 ? r_j_s2 : w_quot;
    end
  end

  assign o_i = r_out;

endmodule

// File: rtl/haze_synth.sv
// haze_synth: forward atmospheric-scattering model,
// I = (J*t + A*(255-t)) / 255 per channel, fixed latency of 3 clocks.
//   pixelclk, reset          : clock and synchronous active-high reset
//   i_rgb                    : clear pixel J {R,G,B}
//   i_transmittance          : t, 255 = fully transparent
//   i_atmos, i_bypass        : requested A and bypass, latched per frame
//   i_hsync, i_vsync, i_de   : input timing
//   o_rgb                    : hazy pixel I (0 when o_de is low)
//   o_hsync, o_vsync, o_de   : timing delayed by 3
//   o_atmos_active           : A shadow currently applied
module haze_synth
  import haze_pkg::*;
#(
  parameter logic [PIX_W-1:0] T_MIN     = T_MIN_DEF,
  parameter logic [PIX_W-1:0] A_RESET   = A_RESET_DEF,
  parameter logic             VSYNC_POL = VSYNC_POL_DEF
) (
  input  logic               pixelclk,
  input  logic               reset,
  input  logic [3*PIX_W-1:0] i_rgb,
  input  logic [PIX_W-1:0]   i_transmittance,
  input  logic [PIX_W-1:0]   i_atmos,
  input  logic               i_bypass,
  input  logic               i_hsync,
  input  logic               i_vsync,
  input  logic               i_de,
  output logic [3*PIX_W-1:0] o_rgb,
  output logic               o_hsync,
  output logic               o_vsync,
  output logic               o_de,
  output logic [PIX_W-1:0]   o_atmos_active
);

  logic               r_vs_d;
  logic [PIX_W-1:0]   r_a_shadow;
  logic               r_byp_shadow;
  logic               w_frame_edge;
  logic [PIX_W-1:0]   w_tc;

  rgb_t               r_j_s1;
  logic [PIX_W-1:0]   r_tc_s1;
  logic [PIX_W-1:0]   r_a_s1;
  logic               r_byp_s1;

  logic [LAT-1:0]     r_hs_pipe;
  logic [LAT-1:0]     r_vs_pipe;
  logic [LAT-1:0]     r_de_pipe;
  logic [3*PIX_W-1:0] w_ch_out;

  assign w_frame_edge = (i_vsync == VSYNC_POL) && (r_vs_d != VSYNC_POL);
  assign w_tc         = (i_transmittance < T_MIN) ? T_MIN : i_transmittance;

  // Shadows update on the vsync leading edge. S1 samples the shadow
  // registers in the same cycle, so a pixel on the edge cycle still sees
  // the previous frame's values.
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      r_vs_d       <= ~VSYNC_POL;  // first active vsync after reset is an edge
      r_a_shadow   <= A_RESET;
      r_byp_shadow <= 1'b0;
    end else begin
      r_vs_d <= i_vsync;
      if (w_frame_edge) begin
        r_a_shadow   <= i_atmos;
        r_byp_shadow <= i_bypass;
      end
    end
  end

  // S1 capture and sync delay line
  always_ff @(posedge pixelclk) begin
    if (reset) begin
      r_j_s1    <= '0;
      r_tc_s1   <= '0;
      r_a_s1    <= '0;
      r_byp_s1  <= 1'b0;
      r_hs_pipe <= '0;
      r_vs_pipe <= '0;
      r_de_pipe <= '0;
    end else begin
      r_j_s1    <= i_rgb;
      r_tc_s1   <= w_tc;
      r_a_s1    <= r_a_shadow;
      r_byp_s1  <= r_byp_shadow;
      r_hs_pipe <= {r_hs_pipe[LAT-2:0], i_hsync};
      r_vs_pipe <= {r_vs_pipe[LAT-2:0], i_vsync};
      r_de_pipe <= {r_de_pipe[LAT-2:0], i_de};
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      haze_channel u_ch (
        .pixelclk (pixelclk),
        .reset    (reset),
        .i_j      (r_j_s1[gi*PIX_W +: PIX_W]),
        .i_tc     (r_tc_s1),
        .i_a      (r_a_s1),
        .i_bypass (r_byp_s1),
        .o_i      (w_ch_out[gi*PIX_W +: PIX_W])
      );
    end
  endgenerate

  // Blanking forces black even in bypass
  assign o_rgb          = r_de_pipe[LAT-1] ? w_ch_out : '0;
  assign o_hsync        = r_hs_pipe[LAT-1];
  assign o_vsync        = r_vs_pipe[LAT-1];
  assign o_de           = r_de_pipe[LAT-1];
  assign o_atmos_active = r_a_shadow;

endmodule

// File: tb/tb_haze_synth.sv
module tb_haze_synth;
  import haze_pkg::*;

  logic        pixelclk = 1'b0;
  logic        reset;
  logic [23:0] i_rgb;
  logic [7:0]  i_transmittance;
  logic [7:0]  i_atmos;
  logic        i_bypass;
  logic        i_hsync;
  logic        i_vsync;
  logic        i_de;
  logic [23:0] o_rgb;
  logic        o_hsync;
  logic        o_vsync;
  logic        o_de;
  logic [7:0]  o_atmos_active;

  int n_chk  = 0;
  int n_pass = 0;

  haze_synth dut (
    .pixelclk        (pixelclk),
    .reset           (reset),
    .i_rgb           (i_rgb),
    .i_transmittance (i_transmittance),
    .i_atmos         (i_atmos),
    .i_bypass        (i_bypass),
    .i_hsync         (i_hsync),
    .i_vsync         (i_vsync),
    .i_de            (i_de),
    .o_rgb           (o_rgb),
    .o_hsync         (o_hsync),
    .o_vsync         (o_vsync),
    .o_de            (o_de),
    .o_atmos_active  (o_atmos_active)
  );

  always #5 pixelclk = ~pixelclk;

  task automatic tick();
    @(posedge pixelclk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    $display("check %-14s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Model of the scattering equation from its definition
  function automatic logic [23:0] model(input logic [23:0] j, input logic [7:0] t,
                                        input logic [7:0] a);
    logic [7:0]  tc;
    logic [23:0] r;
    tc = (t < 8'd26) ? 8'd26 : t;
    for (int c = 0; c < 3; c++)
      r[c*8 +: 8] = div255_floor(16'(j[c*8 +: 8]) * 16'(tc) + 16'(a) * 16'(8'd255 - tc));
    return r;
  endfunction

  // One vsync pulse (2 cycles) carrying a new A and bypass
  task automatic frame(input logic [7:0] a, input logic byp);
    i_de = 1'b0; i_atmos = a; i_bypass = byp; i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
    tick();
  endtask

  // Isolated pixel: one cycle of de, then two blank cycles; result visible after
  task automatic pixel(input logic [23:0] j, input logic [7:0] t);
    i_rgb = j; i_transmittance = t; i_de = 1'b1;
    tick();
    i_de = 1'b0;
    tick();
    tick();
  endtask

  initial begin
    logic [23:0] rj;
    logic [7:0]  rt;
    logic [7:0]  ra;

    reset = 1'b1; i_rgb = '0; i_transmittance = '0; i_atmos = '0; i_bypass = 1'b0;
    i_hsync = 1'b0; i_vsync = 1'b0; i_de = 1'b0;
    tick();
    tick();
    check("rst_rgb",   32'(o_rgb), 0);
    check("rst_de",    32'(o_de), 0);
    check("rst_hsync", 32'(o_hsync), 0);
    check("rst_vsync", 32'(o_vsync), 0);
    check("rst_atmos", 32'(o_atmos_active), 255);
    reset = 1'b0;
    tick();

    // Latch A = 240
    i_atmos = 8'd240; i_vsync = 1'b1;
    tick();
    check("latch_240", 32'(o_atmos_active), 240);
    i_vsync = 1'b0;
    tick();

    // Basic pixel with hsync riding along, sync delay must be exactly 3
    i_rgb = {8'd200, 8'd100, 8'd0}; i_transmittance = 8'd128; i_de = 1'b1; i_hsync = 1'b1;
    tick();
    i_de = 1'b0; i_hsync = 1'b0;
    tick();
    check("hsync_at2", 32'(o_hsync), 0);
    tick();
    check("basic_rgb", 32'(o_rgb), 32'({8'd219, 8'd169, 8'd119}));
    check("basic_de",  32'(o_de), 1);
    check("hsync_at3", 32'(o_hsync), 1);
    tick();
    check("hsync_at4", 32'(o_hsync), 0);
    check("blank_rgb", 32'(o_rgb), 0);

    // Clamp and identity cases with A = 200
    frame(8'd200, 1'b0);
    pixel({8'd100, 8'd100, 8'd100}, 8'd0);
    check("clamp_t0",  32'(o_rgb), 32'({8'd189, 8'd189, 8'd189}));
    pixel({8'd100, 8'd100, 8'd100}, 8'd10);
    check("clamp_t10", 32'(o_rgb), 32'({8'd189, 8'd189, 8'd189}));
    pixel({8'd100, 8'd100, 8'd100}, 8'd26);
    check("t_eq_tmin", 32'(o_rgb), 32'({8'd189, 8'd189, 8'd189}));
    pixel({8'd12, 8'd34, 8'd56}, 8'd255);
    check("t255_ident", 32'(o_rgb), 32'({8'd12, 8'd34, 8'd56}));
    pixel({8'd200, 8'd200, 8'd200}, 8'd77);
    check("j_eq_a", 32'(o_rgb), 32'({8'd200, 8'd200, 8'd200}));

    // Corners
    frame(8'd255, 1'b0);
    pixel({8'd255, 8'd255, 8'd255}, 8'd77);
    check("corner_255", 32'(o_rgb), 32'({8'd255, 8'd255, 8'd255}));
    frame(8'd0, 1'b0);
    pixel(24'd0, 8'd77);
    check("corner_0", 32'(o_rgb), 0);

    // Random sweep against the reference model
    for (int b = 0; b < 20; b++) begin
      ra = 8'($urandom_range(0, 255));
      frame(ra, 1'b0);
      for (int p = 0; p < 40; p++) begin
        rj = 24'($urandom);
        rt = 8'($urandom_range(0, 255));
        pixel(rj, rt);
        check("rand_rgb", 32'(o_rgb), 32'(model(rj, rt, ra)));
      end
    end

    // Mid-frame A change must not apply until the next vsync edge
    frame(8'd100, 1'b0);
    i_atmos = 8'd50;
    tick();
    check("mid_atmos", 32'(o_atmos_active), 100);
    pixel(24'd0, 8'd0);
    check("mid_old_a", 32'(o_rgb), 32'({8'd89, 8'd89, 8'd89}));
    // Pixel on the edge cycle keeps A = 100, the next one gets A = 50
    i_rgb = 24'd0; i_transmittance = 8'd0; i_de = 1'b1; i_vsync = 1'b1;
    tick();
    tick();
    i_de = 1'b0;
    tick();
    check("edge_old_a", 32'(o_rgb), 32'({8'd89, 8'd89, 8'd89}));
    check("vsync_at3",  32'(o_vsync), 1);
    tick();
    check("after_new_a", 32'(o_rgb), 32'({8'd44, 8'd44, 8'd44}));
    check("new_atmos",  32'(o_atmos_active), 50);
    i_vsync = 1'b0;
    tick();

    // Bypass requested mid-frame: ignored until the edge
    i_bypass = 1'b1;
    tick();
    pixel({8'd12, 8'd34, 8'd56}, 8'd0);
    check("byp_pending", 32'(o_rgb), 32'({8'd46, 8'd48, 8'd50}));
    frame(8'd50, 1'b1);
    pixel({8'd12, 8'd34, 8'd56}, 8'd0);
    check("byp_active", 32'(o_rgb), 32'({8'd12, 8'd34, 8'd56}));
    i_rgb = {8'd9, 8'd9, 8'd9}; i_de = 1'b0;
    tick(); tick(); tick();
    check("byp_blank", 32'(o_rgb), 0);
    frame(8'd77, 1'b0);
    check("a_77", 32'(o_atmos_active), 77);

    // Reset for one cycle mid-line
    i_rgb = {8'd1, 8'd2, 8'd3}; i_transmittance = 8'd255; i_de = 1'b1; i_hsync = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; i_de = 1'b0; i_hsync = 1'b0;
    check("mrst_rgb",   32'(o_rgb), 0);
    check("mrst_de",    32'(o_de), 0);
    check("mrst_hsync", 32'(o_hsync), 0);
    check("mrst_atmos", 32'(o_atmos_active), 255);
    tick(); tick();
    check("mrst_flush", 32'(o_de), 0);
    i_atmos = 8'd99; i_vsync = 1'b1;
    tick();
    check("reload_a", 32'(o_atmos_active), 99);
    i_vsync = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
